int_exec_pipe: RTL and testbench
================================

Name: int_exec_pipe

Overview:
- Parametrised, pipelined integer execution block: a multi-lane, multi-latency successor to the single-cycle integer execution stage.
- Executes ALU, shift, compare, conditional-branch and register-indirect-jump ops on LANES parallel lanes.
- Results and branch resolution emerge after LATENCY cycles, under a global stall, a global clear and an active-list-range selective flush.
- Accumulates a saturating mispredict count for performance monitoring.

Parameters:
LANES, 2, number of parallel issue lanes (1..4)
DATA_W, 32, operand/result/address width
LATENCY, 2, pipeline depth in cycles from input capture to output (1..4)
AL_PTR_W, 6, active-list pointer width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  freeze all stages; inputs ignored
clear  in  1  invalidate all in-flight ops at next edge
flush_valid  in  1  selective flush request
flush_head  in  AL_PTR_W  flush range start, inclusive
flush_tail  in  AL_PTR_W  flush range end, exclusive
in_valid  in  LANES  op valid per lane
in_op  in  LANES*4  opcode per lane
in_cond  in  LANES*3  branch condition per lane
in_opa  in  LANES*DATA_W  operand A
in_opb  in  LANES*DATA_W  operand B
in_pc  in  LANES*DATA_W  op PC
in_disp  in  LANES*DATA_W  sign-extended branch displacement
in_pred_taken  in  LANES  predicted direction
in_pred_addr  in  LANES*DATA_W  predicted target
in_al_ptr  in  LANES*AL_PTR_W  active-list pointer
out_valid  out  LANES  result valid
out_data  out  LANES*DATA_W  result data
out_al_ptr  out  LANES*AL_PTR_W  active-list pointer of result
out_br_valid  out  LANES  op is a resolved branch/jump
out_br_taken  out  LANES  resolved direction
out_br_target  out  LANES*DATA_W  resolved next PC
out_mispred  out  LANES  misprediction flag
mispred_count  out  16  saturating total of retired-from-pipe mispredicts

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount = opb[$clog2(DATA_W)-1:0].
  - 8 SLT (signed), 9 SLTU: result 1/0 zero-extended.
  - 10 BR, 11 JALR.
  - 12..15 reserved: result 0, not a branch.
- Conditions: 0 EQ, 1 NE, 2 LT, 3 LTU, 4 GE, 5 GEU, 6 AL (always), 7 NV (never).
- All arithmetic is modulo 2^DATA_W.
- BR:
  - data = pc+4.
  - taken = cond(opa, opb).
  - target = taken ? pc+disp : pc+4.
- JALR:
  - data = pc+4.
  - taken = 1.
  - target = (opa+disp) with bit 0 cleared.
- br_valid = valid and op in {BR, JALR}.
- mispred = br_valid and (pred_taken != taken, or (taken and pred_addr != target)).
- Datapath and latency:
  - Compute is done combinationally at stage-1 input.
  - Then LATENCY register stages; outputs driven directly from the last stage.
  - An op captured at edge N appears on the outputs after edge N+LATENCY-1, absent stall.
- Stall:
  - No stage advances; outputs hold.
  - in_* are not captured.
  - The counter does not increment.
- Clear:
  - Every stage valid = 0 at the next edge.
  - Same-cycle inputs are discarded.
  - Overrides stall.
- Selective flush:
  - Pointer p is in range when head<tail: head<=p<tail; when head>tail (wrap): p>=head or p<tail; when head==tail: empty range.
  - When flush_valid, every in-range op is invalidated at the next edge. This applies to all stages (stalled or not) and to incoming in_valid ops.
  - Out-of-range ops proceed/hold normally.
- Output gating: out_br_valid, out_br_taken and out_mispred are forced 0 when out_valid=0. out_data and out_br_target are don't-care when out_valid=0.
- mispred_count:
  - When !stall, adds popcount(out_valid & out_mispred) each edge.
  - Saturates at 16'hFFFF.
  - Unaffected by clear/flush; cleared only by reset.
- Reset (asynchronous, any time including mid-operation):
  - All stage valids = 0; all outputs 0; mispred_count = 0.
  - The first capture occurs at the first rising edge with rst_n high.
- Lanes are independent; there is no inter-lane forwarding inside the block.

Test Plan:
- LATENCY=2, lane0 ADD opa=5 opb=7 at edge 0 -> out_valid[0]=1, out_data=12 after edge 1, out_br_valid=0. SUB 0-1 -> 32'hFFFFFFFF.
- BR LT opa=-1 opb=0 pc=0x100 disp=0x20 pred_taken=0 -> taken=1, target=0x120, data=0x104, mispred=1, mispred_count 0->1 one cycle after out_valid.
- JALR opa=0x203 disp=0x10 pred_taken=1 pred_addr=0x212 -> target=0x212, mispred=0. Same with pred_addr=0x213 -> mispred=1.
- Stall held 3 cycles with op in last stage -> outputs constant, mispred_count unchanged. clear during stall -> out_valid=0 next edge.
- flush head=60 tail=2 (wrap), in-flight pointers 61, 1, 2 -> 61 and 1 invalidated, 2 survives. head==tail=5 -> nothing flushed.
- Force mispred_count to 16'hFFFE, two lanes mispredict in the same cycle -> count=16'hFFFF and stays. Assert rst_n low mid-pipeline -> all outputs 0 immediately, count 0.

Source files
------------

// File: rtl/int_exec_pipe.sv
// Purpose: multi-lane integer execute (ALU/shift/compare/branch/jump) with branch resolution.
// Latency: LATENCY cycles from input capture to outputs; lanes are fully independent.
// Backpressure: global stall freezes every stage; clear and range flush invalidate in-flight ops.
// Ports: clk/rst_n; stall, clear, flush_valid/head/tail control; in_* per-lane op bundle;
//        out_* per-lane result + branch resolution; mispred_count saturating 16-bit total.
module int_exec_pipe #(
   parameter int LANES    = 2,
   parameter int DATA_W   = 32,
   parameter int LATENCY  = 2,
   parameter int AL_PTR_W = 6
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       stall,
   input  logic                       clear,
   input  logic                       flush_valid,
   input  logic [AL_PTR_W-1:0]        flush_head,
   input  logic [AL_PTR_W-1:0]        flush_tail,
   input  logic [LANES-1:0]           in_valid,
   input  logic [LANES*4-1:0]         in_op,
   input  logic [LANES*3-1:0]         in_cond,
   input  logic [LANES*DATA_W-1:0]    in_opa,
   input  logic [LANES*DATA_W-1:0]    in_opb,
   input  logic [LANES*DATA_W-1:0]    in_pc,
   input  logic [LANES*DATA_W-1:0]    in_disp,
   input  logic [LANES-1:0]           in_pred_taken,
   input  logic [LANES*DATA_W-1:0]    in_pred_addr,
   input  logic [LANES*AL_PTR_W-1:0]  in_al_ptr,
   output logic [LANES-1:0]           out_valid,
   output logic [LANES*DATA_W-1:0]    out_data,
   output logic [LANES*AL_PTR_W-1:0]  out_al_ptr,
   output logic [LANES-1:0]           out_br_valid,
   output logic [LANES-1:0]           out_br_taken,
   output logic [LANES*DATA_W-1:0]    out_br_target,
   output logic [LANES-1:0]           out_mispred,
   output logic [15:0]                mispred_count
);

   localparam int SH_W  = $clog2(DATA_W);
   localparam int CNT_W = $clog2(LANES + 1);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;
   localparam logic [3:0] OP_BR   = 4'd10;
   localparam logic [3:0] OP_JALR = 4'd11;

   typedef struct packed {
      logic                vld;
      logic [DATA_W-1:0]   dat;
      logic [AL_PTR_W-1:0] alPtr;
      logic                brVld;
      logic                brTaken;
      logic [DATA_W-1:0]   brTarget;
      logic                mispred;
   } laneStage_t;

   laneStage_t issue    [LANES];
   laneStage_t pipe     [LATENCY][LANES];
   laneStage_t pipeNext [LATENCY][LANES];

   logic [CNT_W-1:0] retiredMispred;
   logic [16:0]      countSum;

   function automatic logic condMet(input logic [2:0] cond,
                                    input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b);
      case (cond)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd2:    return $signed(a) < $signed(b);
         3'd3:    return a < b;
         3'd4:    return $signed(a) >= $signed(b);
         3'd5:    return a >= b;
         3'd6:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // head==tail is an empty range, not a full one.
   function automatic logic inFlushRange(input logic [AL_PTR_W-1:0] p,
                                         input logic [AL_PTR_W-1:0] h,
                                         input logic [AL_PTR_W-1:0] t);
      if (h < t)      return (p >= h) && (p < t);
      else if (h > t) return (p >= h) || (p < t);
      else            return 1'b0;
   endfunction

   always_comb begin : computeIssue
      logic [DATA_W-1:0] opa, opb, pc, disp, predAddr, pcNext, jumpSum;
      logic [3:0]        op;
      logic [2:0]        cond;
      logic [SH_W-1:0]   shamt;
      for (int l = 0; l < LANES; l++) begin
         opa      = in_opa[l*DATA_W +: DATA_W];
         opb      = in_opb[l*DATA_W +: DATA_W];
         pc       = in_pc[l*DATA_W +: DATA_W];
         disp     = in_disp[l*DATA_W +: DATA_W];
         predAddr = in_pred_addr[l*DATA_W +: DATA_W];
         op       = in_op[l*4 +: 4];
         cond     = in_cond[l*3 +: 3];
         shamt    = opb[SH_W-1:0];
         pcNext   = pc + DATA_W'(4);
         jumpSum  = opa + disp;

         issue[l]       = '0;
         issue[l].vld   = in_valid[l];
         issue[l].alPtr = in_al_ptr[l*AL_PTR_W +: AL_PTR_W];
         case (op)
            OP_ADD:  issue[l].dat = opa + opb;
            OP_SUB:  issue[l].dat = opa - opb;
            OP_AND:  issue[l].dat = opa & opb;
            OP_OR:   issue[l].dat = opa | opb;
            OP_XOR:  issue[l].dat = opa ^ opb;
            OP_SLL:  issue[l].dat = opa << shamt;
            OP_SRL:  issue[l].dat = opa >> shamt;
            OP_SRA:  issue[l].dat = $signed(opa) >>> shamt;
            OP_SLT:  issue[l].dat = DATA_W'($signed(opa) < $signed(opb));
            OP_SLTU: issue[l].dat = DATA_W'(opa < opb);
            OP_BR: begin
               issue[l].dat      = pcNext;
               issue[l].brVld    = 1'b1;
               issue[l].brTaken  = condMet(cond, opa, opb);
               issue[l].brTarget = issue[l].brTaken ? (pc + disp) : pcNext;
            end
            OP_JALR: begin
               issue[l].dat      = pcNext;
               issue[l].brVld    = 1'b1;
               issue[l].brTaken  = 1'b1;
               issue[l].brTarget = {jumpSum[DATA_W-1:1], 1'b0};
            end
            default: issue[l].dat = '0;
         endcase
         issue[l].mispred = issue[l].brVld &
                            ((in_pred_taken[l] != issue[l].brTaken) ||
                             (issue[l].brTaken && (predAddr != issue[l].brTarget)));
      end
   end

   // Flush is evaluated on whatever each stage will hold after the edge, so it
   // covers advancing ops, stalled ops and newly captured ops alike.
   always_comb begin
      pipeNext = pipe;
      if (!stall) begin
         for (int l = 0; l < LANES; l++) begin
            pipeNext[0][l] = issue[l];
            for (int s = 1; s < LATENCY; s++) begin
               pipeNext[s][l] = pipe[s-1][l];
            end
         end
      end
      for (int s = 0; s < LATENCY; s++) begin
         for (int l = 0; l < LANES; l++) begin
            if (clear || (flush_valid &&
                          inFlushRange(pipeNext[s][l].alPtr, flush_head, flush_tail))) begin
               pipeNext[s][l].vld = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < LATENCY; s++) begin
            for (int l = 0; l < LANES; l++) begin
               pipe[s][l] <= '0;
            end
         end
      end else begin
         pipe <= pipeNext;
      end
   end

   genvar g;
   for (g = 0; g < LANES; g++) begin : gOut
      laneStage_t lastStage;
      assign lastStage = pipe[LATENCY-1][g];
      assign out_valid[g]                        = lastStage.vld;
      assign out_data[g*DATA_W +: DATA_W]        = lastStage.dat;
      assign out_al_ptr[g*AL_PTR_W +: AL_PTR_W]  = lastStage.alPtr;
      assign out_br_valid[g]                     = lastStage.vld & lastStage.brVld;
      assign out_br_taken[g]                     = lastStage.vld & lastStage.brTaken;
      assign out_br_target[g*DATA_W +: DATA_W]   = lastStage.brTarget;
      assign out_mispred[g]                      = lastStage.vld & lastStage.mispred;
   end

   always_comb begin
      retiredMispred = '0;
      for (int l = 0; l < LANES; l++) begin
         if (out_valid[l] && out_mispred[l]) retiredMispred = retiredMispred + CNT_W'(1);
      end
      countSum = {1'b0, mispred_count} + 17'(retiredMispred);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mispred_count <= '0;
      end else if (!stall) begin
         mispred_count <= countSum[16] ? 16'hFFFF : countSum[15:0];
      end
   end

endmodule

// File: tb/tb_int_exec_pipe.sv
// Purpose: directed bench for int_exec_pipe with a per-cycle behavioural model comparison.
// Latency: model tracks LATENCY-deep per-lane history; outputs compared every falling edge.
// Backpressure: exercises stall, clear, selective flush, counter saturation and async reset.
module tb_int_exec_pipe;
   localparam int LANES   = 2;
   localparam int DATA_W  = 32;
   localparam int LATENCY = 2;
   localparam int AW      = 6;

   localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, BR = 4'd10, JALR = 4'd11;
   localparam logic [2:0] C_LT = 3'd2, C_GEU = 3'd5, C_AL = 3'd6;

   logic clk = 1'b0, rst_n = 1'b1, stall = 1'b0, clear = 1'b0, flush_valid = 1'b0;
   logic [AW-1:0]            flush_head = '0, flush_tail = '0;
   logic [LANES-1:0]         in_valid = '0, in_pred_taken = '0;
   logic [LANES*4-1:0]       in_op = '0;
   logic [LANES*3-1:0]       in_cond = '0;
   logic [LANES*DATA_W-1:0]  in_opa = '0, in_opb = '0, in_pc = '0, in_disp = '0, in_pred_addr = '0;
   logic [LANES*AW-1:0]      in_al_ptr = '0;
   logic [LANES-1:0]         out_valid, out_br_valid, out_br_taken, out_mispred;
   logic [LANES*DATA_W-1:0]  out_data, out_br_target;
   logic [LANES*AW-1:0]      out_al_ptr;
   logic [15:0]              mispred_count;

   always #5 clk = ~clk;

   int_exec_pipe #(.LANES(LANES), .DATA_W(DATA_W), .LATENCY(LATENCY), .AL_PTR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .clear(clear), .flush_valid(flush_valid),
      .flush_head(flush_head), .flush_tail(flush_tail), .in_valid(in_valid), .in_op(in_op),
      .in_cond(in_cond), .in_opa(in_opa), .in_opb(in_opb), .in_pc(in_pc), .in_disp(in_disp),
      .in_pred_taken(in_pred_taken), .in_pred_addr(in_pred_addr), .in_al_ptr(in_al_ptr),
      .out_valid(out_valid), .out_data(out_data), .out_al_ptr(out_al_ptr),
      .out_br_valid(out_br_valid), .out_br_taken(out_br_taken), .out_br_target(out_br_target),
      .out_mispred(out_mispred), .mispred_count(mispred_count)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   typedef struct packed {
      logic        vld;
      logic [31:0] dat;
      logic [5:0]  ptr;
      logic        brv;
      logic        tk;
      logic [31:0] tgt;
      logic        mp;
   } exp_t;

   exp_t        mdl [LANES][LATENCY];   // index 0 = newest, LATENCY-1 = on the outputs
   logic [15:0] mdlCount;

   function automatic exp_t predict(input logic vld, input logic [3:0] op, input logic [2:0] cond,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] pc, input logic [31:0] disp,
                                    input logic pt, input logic [31:0] pa, input logic [5:0] ptr);
      exp_t e;
      int   sh;
      logic c;
      e = '0;
      e.vld = vld;
      e.ptr = ptr;
      sh = int'(b % 32);
      c = 1'b0;
      case (op)
         4'd0:  e.dat = a + b;
         4'd1:  e.dat = a - b;
         4'd2:  e.dat = a & b;
         4'd3:  e.dat = a | b;
         4'd4:  e.dat = a ^ b;
         4'd5:  e.dat = a << sh;
         4'd6:  e.dat = a >> sh;
         4'd7:  e.dat = 32'($signed(a) >>> sh);
         4'd8:  e.dat = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd9:  e.dat = (a < b) ? 32'd1 : 32'd0;
         4'd10: begin
            case (cond)
               3'd0: c = (a == b);
               3'd1: c = (a != b);
               3'd2: c = ($signed(a) < $signed(b));
               3'd3: c = (a < b);
               3'd4: c = ($signed(a) >= $signed(b));
               3'd5: c = (a >= b);
               3'd6: c = 1'b1;
               default: c = 1'b0;
            endcase
            e.brv = 1'b1;
            e.tk  = c;
            e.dat = pc + 32'd4;
            e.tgt = c ? (pc + disp) : (pc + 32'd4);
         end
         4'd11: begin
            e.brv = 1'b1;
            e.tk  = 1'b1;
            e.dat = pc + 32'd4;
            e.tgt = (a + disp) & 32'hFFFF_FFFE;
         end
         default: e.dat = 32'd0;
      endcase
      e.mp = e.brv && ((pt != e.tk) || (e.tk && (pa != e.tgt)));
      return e;
   endfunction

   // Range membership as modular distance from head compared with range length.
   function automatic logic inRange(input logic [5:0] p, input logic [5:0] h, input logic [5:0] t);
      logic [5:0] off, len;
      off = p - h;
      len = t - h;
      return off < len;
   endfunction

   initial begin : modelProc
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int l = 0; l < LANES; l++)
               for (int s = 0; s < LATENCY; s++) mdl[l][s] = '0;
            mdlCount = 16'd0;
         end else begin
            if (!stall) begin
               int n, total;
               n = 0;
               for (int l = 0; l < LANES; l++)
                  if (mdl[l][LATENCY-1].vld && mdl[l][LATENCY-1].mp) n++;
               total = int'(mdlCount) + n;
               mdlCount = (total > 65535) ? 16'hFFFF : 16'(total);
               for (int l = 0; l < LANES; l++) begin
                  for (int s = LATENCY - 1; s > 0; s--) mdl[l][s] = mdl[l][s-1];
                  mdl[l][0] = predict(in_valid[l], in_op[l*4 +: 4], in_cond[l*3 +: 3],
                                      in_opa[l*32 +: 32], in_opb[l*32 +: 32], in_pc[l*32 +: 32],
                                      in_disp[l*32 +: 32], in_pred_taken[l],
                                      in_pred_addr[l*32 +: 32], in_al_ptr[l*6 +: 6]);
               end
            end
            for (int l = 0; l < LANES; l++)
               for (int s = 0; s < LATENCY; s++) begin
                  if (clear) mdl[l][s].vld = 1'b0;
                  if (flush_valid && inRange(mdl[l][s].ptr, flush_head, flush_tail))
                     mdl[l][s].vld = 1'b0;
               end
         end
      end
   end

   initial begin : compareProc
      forever begin
         @(negedge clk);
         if (rst_n) begin
            for (int l = 0; l < LANES; l++) begin
               exp_t m;
               m = mdl[l][LATENCY-1];
               chk($sformatf("cmp_valid[%0d]", l), out_valid[l], m.vld);
               if (m.vld) begin
                  chk($sformatf("cmp_data[%0d]", l), out_data[l*32 +: 32], m.dat);
                  chk($sformatf("cmp_ptr[%0d]", l), out_al_ptr[l*6 +: 6], m.ptr);
                  chk($sformatf("cmp_brv[%0d]", l), out_br_valid[l], m.brv);
                  chk($sformatf("cmp_mispred[%0d]", l), out_mispred[l], m.mp);
                  if (m.brv) begin
                     chk($sformatf("cmp_taken[%0d]", l), out_br_taken[l], m.tk);
                     chk($sformatf("cmp_target[%0d]", l), out_br_target[l*32 +: 32], m.tgt);
                  end
               end else begin
                  chk($sformatf("cmp_gate_brv[%0d]", l), out_br_valid[l], 1'b0);
                  chk($sformatf("cmp_gate_taken[%0d]", l), out_br_taken[l], 1'b0);
                  chk($sformatf("cmp_gate_mispred[%0d]", l), out_mispred[l], 1'b0);
               end
            end
            chk("cmp_count", mispred_count, mdlCount);
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid = '0; stall = 1'b0; clear = 1'b0; flush_valid = 1'b0;
   endtask

   task automatic setLane(input int l, input logic [3:0] op, input logic [2:0] cond,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                          input logic [31:0] disp, input logic pt, input logic [31:0] pa,
                          input logic [5:0] ptr);
      in_valid[l]            = 1'b1;
      in_op[l*4 +: 4]        = op;
      in_cond[l*3 +: 3]      = cond;
      in_opa[l*32 +: 32]     = a;
      in_opb[l*32 +: 32]     = b;
      in_pc[l*32 +: 32]      = pc;
      in_disp[l*32 +: 32]    = disp;
      in_pred_taken[l]       = pt;
      in_pred_addr[l*32 +: 32] = pa;
      in_al_ptr[l*6 +: 6]    = ptr;
   endtask

   localparam logic [3:0]  T_OP [9] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd2, 4'd3, 4'd4, 4'd12};
   localparam logic [31:0] T_A  [9] = '{32'd1, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                                        32'hFFFF_FFFF, 32'hF0F0, 32'hF0F0, 32'hFF, 32'd5};
   localparam logic [31:0] T_B  [9] = '{32'd33, 32'd4, 32'd4, 32'd1, 32'd1, 32'hFF00,
                                        32'h0F0F, 32'h0F, 32'd7};
   localparam logic [31:0] T_E  [9] = '{32'd2, 32'h0800_0000, 32'hF800_0000, 32'd1, 32'd0,
                                        32'hF000, 32'hFFFF, 32'hF0, 32'd0};

   initial begin : stimulus
      #1 rst_n = 1'b0;
      repeat (2) cyc();
      chk("rst_valid", out_valid, 2'b00);
      chk("rst_data", out_data, 64'd0);
      chk("rst_count", mispred_count, 16'd0);
      rst_n = 1'b1;
      cyc();

      // ADD / SUB, two lanes
      setLane(0, ADD, 3'd0, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 32'd0, 6'd3);
      setLane(1, SUB, 3'd0, 32'd0, 32'd1, 32'd0, 32'd0, 1'b0, 32'd0, 6'd4);
      cyc(); idle(); cyc();
      chk("add_valid", out_valid, 2'b11);
      chk("add_data", out_data[31:0], 32'd12);
      chk("sub_data", out_data[63:32], 32'hFFFF_FFFF);
      chk("add_brv", out_br_valid, 2'b00);
      cyc();

      // ALU / shift / compare table on lane 0
      for (int i = 0; i < 9; i++) begin
         setLane(0, T_OP[i], 3'd0, T_A[i], T_B[i], 32'd0, 32'd0, 1'b0, 32'd0, 6'(i + 10));
         cyc(); idle(); cyc();
         chk($sformatf("alu%0d_data", i), out_data[31:0], T_E[i]);
      end
      cyc();

      // BR LT taken, predicted not-taken
      setLane(0, BR, C_LT, 32'hFFFF_FFFF, 32'd0, 32'h100, 32'h20, 1'b0, 32'd0, 6'd7);
      cyc(); idle(); cyc();
      chk("br_brv", out_br_valid, 2'b01);
      chk("br_taken", out_br_taken, 2'b01);
      chk("br_target", out_br_target[31:0], 32'h120);
      chk("br_data", out_data[31:0], 32'h104);
      chk("br_mispred", out_mispred, 2'b01);
      chk("br_count_before", mispred_count, 16'd0);
      cyc();
      chk("br_count_after", mispred_count, 16'd1);

      // BR GEU not taken, predicted not-taken
      setLane(0, BR, C_GEU, 32'd1, 32'd2, 32'h200, 32'h40, 1'b0, 32'd0, 6'd8);
      cyc(); idle(); cyc();
      chk("brnt_taken", out_br_taken, 2'b00);
      chk("brnt_target", out_br_target[31:0], 32'h204);
      chk("brnt_mispred", out_mispred, 2'b00);
      cyc();

      // JALR correct vs wrong predicted address
      setLane(0, JALR, 3'd0, 32'h203, 32'd0, 32'h300, 32'h10, 1'b1, 32'h212, 6'd8);
      setLane(1, JALR, 3'd0, 32'h203, 32'd0, 32'h300, 32'h10, 1'b1, 32'h213, 6'd9);
      cyc(); idle(); cyc();
      chk("jalr_target0", out_br_target[31:0], 32'h212);
      chk("jalr_target1", out_br_target[63:32], 32'h212);
      chk("jalr_taken", out_br_taken, 2'b11);
      chk("jalr_mispred", out_mispred, 2'b10);
      chk("jalr_data", out_data[31:0], 32'h304);
      cyc();
      chk("jalr_count", mispred_count, 16'd2);

      // Stall with a mispredicting branch on the outputs, then clear while stalled
      setLane(0, BR, C_AL, 32'd0, 32'd0, 32'h40, 32'd8, 1'b0, 32'd0, 6'd10);
      cyc(); idle(); cyc();
      stall = 1'b1;
      setLane(0, ADD, 3'd0, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 32'd0, 6'd11);
      setLane(1, ADD, 3'd0, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 32'd0, 6'd12);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("stall_valid", out_valid, 2'b01);
         chk("stall_target", out_br_target[31:0], 32'h48);
         chk("stall_count", mispred_count, 16'd2);
      end
      clear = 1'b1;
      cyc();
      chk("clear_valid", out_valid, 2'b00);
      chk("clear_count", mispred_count, 16'd2);
      idle();
      repeat (2) cyc();
      chk("post_clear_valid", out_valid, 2'b00);

      // Wrapping flush 60..2: 61 and 1 in flight die, incoming 2 survives
      setLane(0, ADD, 3'd0, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 32'd0, 6'd61);
      setLane(1, ADD, 3'd0, 32'd2, 32'd2, 32'd0, 32'd0, 1'b0, 32'd0, 6'd1);
      cyc();
      idle();
      setLane(0, ADD, 3'd0, 32'd3, 32'd3, 32'd0, 32'd0, 1'b0, 32'd0, 6'd2);
      flush_valid = 1'b1; flush_head = 6'd60; flush_tail = 6'd2;
      cyc();
      chk("flush_wrap_killed", out_valid, 2'b00);
      idle();
      cyc();
      chk("flush_wrap_kept", out_valid, 2'b01);
      chk("flush_wrap_ptr", out_al_ptr[5:0], 6'd2);
      chk("flush_wrap_data", out_data[31:0], 32'd6);

      // head == tail: empty range
      setLane(0, ADD, 3'd0, 32'd4, 32'd4, 32'd0, 32'd0, 1'b0, 32'd0, 6'd5);
      setLane(1, ADD, 3'd0, 32'd5, 32'd5, 32'd0, 32'd0, 1'b0, 32'd0, 6'd5);
      flush_valid = 1'b1; flush_head = 6'd5; flush_tail = 6'd5;
      cyc(); idle(); cyc();
      chk("flush_empty_valid", out_valid, 2'b11);
      chk("flush_empty_data", out_data[31:0], 32'd8);

      // Flush of stalled last stage: head inclusive, tail exclusive
      setLane(0, ADD, 3'd0, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 6'd20);
      setLane(1, ADD, 3'd0, 32'd2, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 6'd21);
      cyc(); idle(); cyc();
      stall = 1'b1; flush_valid = 1'b1; flush_head = 6'd20; flush_tail = 6'd21;
      cyc();
      chk("flush_stalled_valid", out_valid, 2'b10);
      idle();
      cyc();

      // Saturation: 32766 pairs of mispredicts take the count from 2 to 16'hFFFE
      setLane(0, BR, C_AL, 32'd0, 32'd0, 32'h0, 32'h8, 1'b0, 32'd0, 6'd0);
      setLane(1, BR, C_AL, 32'd0, 32'd0, 32'h0, 32'h8, 1'b0, 32'd0, 6'd0);
      repeat (32766) cyc();
      idle();
      repeat (3) cyc();
      chk("sat_pre", mispred_count, 16'hFFFE);
      in_valid = 2'b11;
      cyc(); idle(); cyc(); cyc();
      chk("sat_hit", mispred_count, 16'hFFFF);
      in_valid = 2'b11;
      cyc(); idle(); repeat (3) cyc();
      chk("sat_hold", mispred_count, 16'hFFFF);

      // Asynchronous reset mid-pipeline
      setLane(0, ADD, 3'd0, 32'd7, 32'd7, 32'd0, 32'd0, 1'b0, 32'd0, 6'd30);
      setLane(1, JALR, 3'd0, 32'h203, 32'd0, 32'h300, 32'h10, 1'b0, 32'd0, 6'd31);
      cyc(); cyc();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 2'b00);
      chk("arst_data", out_data, 64'd0);
      chk("arst_target", out_br_target, 64'd0);
      chk("arst_ptr", out_al_ptr, 12'd0);
      chk("arst_count", mispred_count, 16'd0);
      idle();
      cyc();
      rst_n = 1'b1;
      repeat (2) cyc();
      chk("arst_after_valid", out_valid, 2'b00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
